// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encodings,
// port-index constants and default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  // Port indices double as the grant encoding.
  localparam logic PORT_IC = 1'b0;  // instruction cache
  localparam logic PORT_DC = 1'b1;  // data cache

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational grant selection for the memory arbiter.
// Optional feature: define MEM_ARB_RR_EN for round-robin on contention;
// otherwise the data-cache port always wins a tie.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

`ifdef MEM_ARB_RR_EN
  // On a tie, hand the grant to the port that was not served last.
  always_comb begin
    if (req == 2'b11) begin
      grant = ~last;
    end else begin
      grant = req[1] ? PORT_DC : PORT_IC;
    end
  end
`else
  // Fixed priority never looks at history.
  logic unused_last;
  assign unused_last = last;

  // Data cache first whenever it asks.
  always_comb begin
    grant = req[1] ? PORT_DC : PORT_IC;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single memory with a
// busywait handshake. One transfer at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_busywait,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  state_e              state_q, state_d;
  logic                grant_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic [1:0]          req;
  logic                pick_grant;
  logic                last_grant;
  logic                accept;

  assign req    = {p1_read | p1_write, p0_read | p0_write};
  assign accept = (state_q == IDLE) && (|req);

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Remember who was granted most recently for tie breaking.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      last_q <= PORT_IC;
    end else if (accept) begin
      last_q <= pick_grant;
    end
  end

  assign last_grant = last_q;
`else
  assign last_grant = PORT_IC;
`endif

  arb_pick u_arb_pick (
    .req   (req),
    .last  (last_grant),
    .grant (pick_grant)
  );

  // State register.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (|req)         state_d = ISSUE;
      ISSUE: if (mem_busywait) state_d = WAIT;
      WAIT:  if (!mem_busywait) state_d = DONE;
      DONE:                    state_d = IDLE;
    endcase
  end

  // Latch the winning request; a write bit wins over a simultaneous read.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      grant_q <= PORT_IC;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      grant_q <= pick_grant;
      write_q <= pick_grant ? p1_write     : p0_write;
      addr_q  <= pick_grant ? p1_address   : p0_address;
      wdata_q <= pick_grant ? p1_writedata : p0_writedata;
    end
  end

  // Capture returning read data into the granted port only.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if ((state_q == WAIT) && !mem_busywait && !write_q) begin
      if (grant_q == PORT_DC) begin
        rdata1_q <= mem_readdata;
      end else begin
        rdata0_q <= mem_readdata;
      end
    end
  end

  // Output decode: memory strobes in ISSUE/WAIT, busywait release in DONE.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    p0_busywait = req[0];
    p1_busywait = req[1];
    if ((state_q == ISSUE) || (state_q == WAIT)) begin
      mem_read  = ~write_q;
      mem_write = write_q;
    end
    if (state_q == DONE) begin
      if (grant_q == PORT_DC) begin
        p1_busywait = 1'b0;
      end else begin
        p0_busywait = 1'b0;
      end
    end
  end

  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign p0_readdata   = rdata0_q;
  assign p1_readdata   = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// and a simple latency-programmable memory.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [5:0]  p0_address, p1_address;
  logic [31:0] p0_writedata, p1_writedata;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_busywait, p1_busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;
  int lat     = 5;

  always #5 CLK = ~CLK;

  mem_arbiter dut (
    .CLK           (CLK),
    .reset         (reset),
    .p0_read       (p0_read),
    .p0_write      (p0_write),
    .p0_address    (p0_address),
    .p0_writedata  (p0_writedata),
    .p0_readdata   (p0_readdata),
    .p0_busywait   (p0_busywait),
    .p1_read       (p1_read),
    .p1_write      (p1_write),
    .p1_address    (p1_address),
    .p1_writedata  (p1_writedata),
    .p1_readdata   (p1_readdata),
    .p1_busywait   (p1_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- memory: preloaded pattern, fixed latency ----------------
  logic [31:0] memarr [64];
  int          mcnt;
  int          mphase;
  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) memarr[i] <= 32'hC0DE_0000 | i;
      memarr[5]    <= 32'hDEAD_BEEF;
      mem_busywait <= 1'b0;
      mem_readdata <= 32'h0;
      mcnt         <= 0;
      mphase       <= 0;
    end else begin
      case (mphase)
        0: if (mem_read || mem_write) begin
             mem_busywait <= 1'b1;
             mcnt         <= lat;
             mphase       <= 1;
           end
        1: if (mcnt <= 1) begin
             mem_busywait <= 1'b0;
             if (mem_write) memarr[mem_address] <= mem_writedata;
             else           mem_readdata <= memarr[mem_address];
             mphase <= 2;
           end else mcnt <= mcnt - 1;
        default: if (!(mem_read || mem_write)) mphase <= 0;
      endcase
    end
  end

  // ---------------- reference model: one outstanding transaction ----------------
  // m_busy: a transaction owns the memory; m_seen: memory has accepted it;
  // m_done: the single release cycle after memory completion.
  logic        m_busy, m_seen, m_done, m_g, m_wr, m_last;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata, m_rd0, m_rd1;
  always @(posedge CLK or negedge reset) begin
    logic r0, r1, g;
    if (!reset) begin
      m_busy <= 0; m_seen <= 0; m_done <= 0; m_g <= 0; m_wr <= 0; m_last <= 0;
      m_addr <= 0; m_wdata <= 0; m_rd0 <= 0; m_rd1 <= 0;
    end else if (!m_busy) begin
      r0 = p0_read | p0_write;
      r1 = p1_read | p1_write;
`ifdef MEM_ARB_RR_EN
      g = (r0 && r1) ? ~m_last : r1;
`else
      g = r1;
`endif
      if (r0 || r1) begin
        m_busy  <= 1; m_seen <= 0; m_done <= 0;
        m_g     <= g;  m_last <= g;
        m_wr    <= g ? p1_write : p0_write;
        m_addr  <= g ? p1_address : p0_address;
        m_wdata <= g ? p1_writedata : p0_writedata;
      end
    end else if (m_done) begin
      m_busy <= 0; m_done <= 0;
    end else if (!m_seen) begin
      if (mem_busywait) m_seen <= 1;
    end else if (!mem_busywait) begin
      if (!m_wr) begin
        if (m_g) m_rd1 <= mem_readdata;
        else     m_rd0 <= mem_readdata;
      end
      m_done <= 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    logic act;
    if (chk_en) begin
      act = m_busy && !m_done;
      check("mem_read",      mem_read,      act && !m_wr);
      check("mem_write",     mem_write,     act && m_wr);
      check("mem_address",   mem_address,   m_addr);
      check("mem_writedata", mem_writedata, m_wdata);
      check("p0_readdata",   p0_readdata,   m_rd0);
      check("p1_readdata",   p1_readdata,   m_rd1);
      check("p0_busywait",   p0_busywait,   (p0_read | p0_write) && !(m_done && m_g == 1'b0));
      check("p1_busywait",   p1_busywait,   (p1_read | p1_write) && !(m_done && m_g == 1'b1));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_bw_low(input int port, input string name);
    for (int n = 0; n < 60; n++) begin
      step();
      if ((port == 1 ? p1_busywait : p0_busywait) == 1'b0) return;
    end
    check({name, "_timeout"}, port == 1 ? p1_busywait : p0_busywait, 32'd0);
  endtask

  initial begin
    int first, second;
    reset = 1'b0;
    p0_read = 0; p0_write = 0; p0_address = 0; p0_writedata = 0;
    p1_read = 0; p1_write = 0; p1_address = 0; p1_writedata = 0;
    step(); step();
    check("rst_mem_read",    mem_read,    32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_p0_readdata", p0_readdata, 32'd0);
    check("rst_p1_busywait", p1_busywait, 32'd0);
    reset  = 1'b1;
    chk_en = 1'b1;
    step();

    // Port 0 read from 0x05 with 5-cycle memory latency.
    p0_read = 1; p0_address = 6'h05;
    step();
    check("t1_issue_mem_read", mem_read,    32'd1);
    check("t1_issue_addr",     mem_address, 32'h05);
    wait_bw_low(0, "t1");
    check("t1_rdata",          p0_readdata, 32'hDEAD_BEEF);
    check("t1_done_mem_read",  mem_read,    32'd0);
    $display("txn p0 read  addr=05 data=%h", p0_readdata);
    p0_read = 0;
    step();

    // Port 1 write to 0x2A.
    p1_write = 1; p1_address = 6'h2A; p1_writedata = 32'h1234_5678;
    step();
    check("t2_mem_write", mem_write,     32'd1);
    check("t2_wdata",     mem_writedata, 32'h1234_5678);
    wait_bw_low(1, "t2");
    check("t2_mem_stored", memarr[6'h2A], 32'h1234_5678);
    check("t2_p1_rdata",   p1_readdata,   32'd0);
    $display("txn p1 write addr=2A data=%h", mem_writedata);
    p1_write = 0;
    step();

    // Both ports read at once.
`ifdef MEM_ARB_RR_EN
    first = 0;
`else
    first = 1;
`endif
    second = 1 - first;
    p0_read = 1; p0_address = 6'h10;
    p1_read = 1; p1_address = 6'h20;
    wait_bw_low(first, "t3a");
    check("t3a_other_busy", second == 1 ? p1_busywait : p0_busywait, 32'd1);
    check("t3a_rdata", first == 1 ? p1_readdata : p0_readdata,
          first == 1 ? 32'hC0DE_0020 : 32'hC0DE_0010);
    $display("txn p%0d read (contended) first", first);
    if (first == 1) p1_read = 0; else p0_read = 0;
    wait_bw_low(second, "t3b");
    check("t3b_rdata", second == 1 ? p1_readdata : p0_readdata,
          second == 1 ? 32'hC0DE_0020 : 32'hC0DE_0010);
    $display("txn p%0d read (contended) second", second);
    p0_read = 0; p1_read = 0;
    step();

    // Port 1 read+write together behaves as a write.
    p1_read = 1; p1_write = 1; p1_address = 6'h11; p1_writedata = 32'hA5A5_5A5A;
    step();
    check("t4_mem_write", mem_write,   32'd1);
    check("t4_mem_read",  mem_read,    32'd0);
    check("t4_addr",      mem_address, 32'h11);
    wait_bw_low(1, "t4");
    check("t4_mem_stored", memarr[6'h11], 32'hA5A5_5A5A);
    check("t4_p1_rdata",   p1_readdata,   32'hC0DE_0020);
    $display("txn p1 rd+wr addr=11 treated as write");
    p1_read = 0; p1_write = 0;
    step();

    // Reset during WAIT of a port 1 read, then re-run.
    p1_read = 1; p1_address = 6'h21;
    for (int n = 0; n < 20 && !mem_busywait; n++) step();
    step();
    check("t5_in_wait", mem_read, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_mem_read", mem_read,    32'd0);
    check("t5_rst_p1_rdata", p1_readdata, 32'd0);
    check("t5_rst_addr",     mem_address, 32'd0);
    check("t5_rst_p1_busy",  p1_busywait, 32'd1);
    step(); step();
    reset = 1'b1;
    wait_bw_low(1, "t5");
    check("t5_rdata", p1_readdata, 32'hC0DE_0021);
    $display("txn p1 read  addr=21 after reset data=%h", p1_readdata);
    p1_read = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
